// File: rtl/reu_bus_arb_pkg.sv
// Shared types and default timing constants for the REU bus-slot responder.
package reu_bus_arb_pkg;

   localparam int SLOT_LEN_DEF   = 16;
   localparam int HALT_SLOTS_DEF = 3;
   localparam int RAM_PERIOD_DEF = 8;
   localparam int RAM_WIN_DEF    = 4;
   localparam int RD_LAT_DEF     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HALT  = 2'd1,
      READY = 2'd2,
      GRANT = 2'd3
   } arb_state_t;

   // Width of a down-counter able to hold the larger of two load values.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reu_ram_slot.sv
// RAM-side window generator: free-running phase counter, request capture and
// fixed-latency SDRAM port. Outputs are registered from the phase register, so
// the visible window phase trails the phase register by one clock; this lets
// the first window start on the first clock after reset with all outputs low
// while reset is held.
module reu_ram_slot
   import reu_bus_arb_pkg::*;
#(
   parameter int RAM_PERIOD = RAM_PERIOD_DEF,
   parameter int RAM_WIN    = RAM_WIN_DEF,
   parameter int RD_LAT     = RD_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [24:0] ram_addr,
   input  logic [7:0]  ram_dout,
   input  logic        ram_we,
   output logic        ram_cycle,
   output logic [7:0]  ram_din,
   output logic        sdram_ce,
   output logic        sdram_we,
   output logic [24:0] sdram_addr,
   output logic [7:0]  sdram_din,
   input  logic [7:0]  sdram_dout
);

   localparam int PW = (RAM_PERIOD > 1) ? $clog2(RAM_PERIOD) : 1;

   logic [PW-1:0] phase;

   // Phase counter, window strobe, phase-0 capture and read-data return.
   // sdram_we doubles as the captured direction flag for the whole window.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase      <= '0;
         ram_cycle  <= 1'b0;
         sdram_ce   <= 1'b0;
         sdram_we   <= 1'b0;
         sdram_addr <= '0;
         sdram_din  <= '0;
         ram_din    <= 8'hFF;
      end else begin
         phase     <= (phase == PW'(RAM_PERIOD - 1)) ? '0 : phase + PW'(1);
         ram_cycle <= (phase < PW'(RAM_WIN));
         sdram_ce  <= (phase == '0);
         if (phase == '0) begin
            sdram_addr <= ram_addr;
            sdram_we   <= ram_we;
            sdram_din  <= ram_dout;
         end
         if ((phase == PW'(RD_LAT + 1)) && !sdram_we)
            ram_din <= sdram_dout;
      end
   end

endmodule

// File: rtl/reu_bus_arb.sv
// REU bus-slot responder: halts the CPU, waits out the bus handover, grants
// slot-aligned DMA windows on the C64 bus and runs the RAM-side window.
//
// state | meaning
// IDLE  | CPU owns the bus, no DMA pending
// HALT  | cpu_halt raised, counting handover slots
// READY | waiting for a slot the VIC does not own
// GRANT | DMA window, SLOT_LEN clocks, never truncated
module reu_bus_arb
   import reu_bus_arb_pkg::*;
#(
   parameter int SLOT_LEN   = SLOT_LEN_DEF,
   parameter int HALT_SLOTS = HALT_SLOTS_DEF,
   parameter int RAM_PERIOD = RAM_PERIOD_DEF,
   parameter int RAM_WIN    = RAM_WIN_DEF,
   parameter int RD_LAT     = RD_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        slot_start,
   input  logic        vic_ba,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_we,
   output logic        cpu_halt,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_dout,
   input  logic        dma_we,
   output logic        dma_cycle,
   output logic [7:0]  dma_din,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_we,
   input  logic [7:0]  bus_din,
   input  logic [24:0] ram_addr,
   input  logic [7:0]  ram_dout,
   input  logic        ram_we,
   output logic        ram_cycle,
   output logic [7:0]  ram_din,
   output logic        sdram_ce,
   output logic        sdram_we,
   output logic [24:0] sdram_addr,
   output logic [7:0]  sdram_din,
   input  logic [7:0]  sdram_dout
);

   localparam int CW = cnt_width(SLOT_LEN, HALT_SLOTS);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          slot_ok;

   assign slot_ok = slot_start && vic_ba && dma_req;

   // State and shared slot/window down-counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state; a window ending on a slot boundary can re-grant with no gap.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (dma_req) begin
               state_nxt = HALT;
               cnt_nxt   = CW'(HALT_SLOTS);
            end
         end
         HALT: begin
            if (cnt == '0)
               state_nxt = READY;
            else if (slot_start)
               cnt_nxt = cnt - CW'(1);
         end
         READY: begin
            if (!dma_req)
               state_nxt = IDLE;
            else if (slot_start && vic_ba) begin
               state_nxt = GRANT;
               cnt_nxt   = CW'(SLOT_LEN - 1);
            end
         end
         GRANT: begin
            if (cnt != '0)
               cnt_nxt = cnt - CW'(1);
            else if (slot_ok)
               cnt_nxt = CW'(SLOT_LEN - 1);
            else
               state_nxt = READY;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and C64 bus mux; CPU writes are blocked while handing over.
   always_comb begin
      cpu_halt  = (state != IDLE);
      dma_cycle = (state == GRANT);
      bus_addr  = cpu_addr;
      bus_dout  = cpu_dout;
      bus_we    = cpu_we;
      if (state == GRANT) begin
         bus_addr = dma_addr;
         bus_dout = dma_dout;
         bus_we   = dma_we;
      end else if ((state == HALT) || (state == READY)) begin
         bus_we = 1'b0;
      end
   end

   // DMA read data follows the bus during a window and holds outside it.
   always_ff @(posedge clk) begin
      if (reset)
         dma_din <= 8'hFF;
      else if (state == GRANT)
         dma_din <= bus_din;
   end

   reu_ram_slot #(
      .RAM_PERIOD (RAM_PERIOD),
      .RAM_WIN    (RAM_WIN),
      .RD_LAT     (RD_LAT)
   ) u_ram_slot (
      .clk        (clk),
      .reset      (reset),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .ram_we     (ram_we),
      .ram_cycle  (ram_cycle),
      .ram_din    (ram_din),
      .sdram_ce   (sdram_ce),
      .sdram_we   (sdram_we),
      .sdram_addr (sdram_addr),
      .sdram_din  (sdram_din),
      .sdram_dout (sdram_dout)
   );

endmodule

// File: tb/tb_reu_bus_arb.sv
// Directed bench for reu_bus_arb with hand-computed expectations.
module tb_reu_bus_arb;

   logic        clk;
   logic        reset;
   logic        slot_start;
   logic        vic_ba;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_we;
   logic        cpu_halt;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic [7:0]  dma_dout;
   logic        dma_we;
   logic        dma_cycle;
   logic [7:0]  dma_din;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic        bus_we;
   logic [7:0]  bus_din;
   logic [24:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic        ram_cycle;
   logic [7:0]  ram_din;
   logic        sdram_ce;
   logic        sdram_we;
   logic [24:0] sdram_addr;
   logic [7:0]  sdram_din;
   logic [7:0]  sdram_dout;

   int   n_tests;
   int   n_fail;
   int   cur_t;
   logic e_dma;
   logic e_halt;

   reu_bus_arb dut (
      .clk        (clk),
      .reset      (reset),
      .slot_start (slot_start),
      .vic_ba     (vic_ba),
      .cpu_addr   (cpu_addr),
      .cpu_dout   (cpu_dout),
      .cpu_we     (cpu_we),
      .cpu_halt   (cpu_halt),
      .dma_req    (dma_req),
      .dma_addr   (dma_addr),
      .dma_dout   (dma_dout),
      .dma_we     (dma_we),
      .dma_cycle  (dma_cycle),
      .dma_din    (dma_din),
      .bus_addr   (bus_addr),
      .bus_dout   (bus_dout),
      .bus_we     (bus_we),
      .bus_din    (bus_din),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .ram_we     (ram_we),
      .ram_cycle  (ram_cycle),
      .ram_din    (ram_din),
      .sdram_ce   (sdram_ce),
      .sdram_we   (sdram_we),
      .sdram_addr (sdram_addr),
      .sdram_din  (sdram_din),
      .sdram_dout (sdram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%h exp=%h", tag, cur_t, got, exp);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      cur_t      = -1;
      reset      = 1'b1;
      slot_start = 1'b0;
      vic_ba     = 1'b1;
      cpu_addr   = 16'h1234;
      cpu_dout   = 8'h77;
      cpu_we     = 1'b1;
      dma_req    = 1'b0;
      dma_addr   = 16'hD020;
      dma_dout   = 8'h05;
      dma_we     = 1'b1;
      bus_din    = 8'h00;
      ram_addr   = '0;
      ram_dout   = 8'h00;
      ram_we     = 1'b0;
      sdram_dout = 8'hEE;
      repeat (3) step();
      #1;
      chk("rst_cpu_halt",   32'(cpu_halt),   32'd0);
      chk("rst_dma_cycle",  32'(dma_cycle),  32'd0);
      chk("rst_ram_cycle",  32'(ram_cycle),  32'd0);
      chk("rst_sdram_ce",   32'(sdram_ce),   32'd0);
      chk("rst_sdram_we",   32'(sdram_we),   32'd0);
      chk("rst_sdram_addr", 32'(sdram_addr), 32'd0);
      chk("rst_sdram_din",  32'(sdram_din),  32'd0);
      chk("rst_dma_din",    32'(dma_din),    32'hFF);
      chk("rst_ram_din",    32'(ram_din),    32'hFF);
      chk("rst_bus_addr",   32'(bus_addr),   32'h1234);
      chk("rst_bus_we",     32'(bus_we),     32'd1);

      // RAM side: read window then write window, starting right after reset.
      reset    = 1'b0;
      ram_addr = 25'h1000123;
      ram_we   = 1'b0;
      ram_dout = 8'h11;
      step();
      for (int k = 0; k < 16; k++) begin
         cur_t      = 1000 + k;
         sdram_dout = (k == 2) ? 8'h3C : ((k >= 8) ? 8'h42 : 8'hEE);
         if (k == 7) begin
            ram_addr = 25'h0000ABC;
            ram_we   = 1'b1;
            ram_dout = 8'h99;
         end
         #1;
         chk("ram_cycle", 32'(ram_cycle), ((k % 8) < 4) ? 32'd1 : 32'd0);
         chk("sdram_ce",  32'(sdram_ce),  ((k % 8) == 0) ? 32'd1 : 32'd0);
         case (k)
            0: begin
               chk("rd_sdram_addr", 32'(sdram_addr), 32'h1000123);
               chk("rd_sdram_we",   32'(sdram_we),   32'd0);
               chk("rd_sdram_din",  32'(sdram_din),  32'h11);
            end
            2:  chk("rd_ram_din_ph2", 32'(ram_din), 32'hFF);
            3:  chk("rd_ram_din_ph3", 32'(ram_din), 32'h3C);
            8: begin
               chk("wr_sdram_addr", 32'(sdram_addr), 32'h0000ABC);
               chk("wr_sdram_we",   32'(sdram_we),   32'd1);
               chk("wr_sdram_din",  32'(sdram_din),  32'h99);
            end
            11: chk("wr_ram_din_ph3", 32'(ram_din), 32'h3C);
            15: chk("wr_ram_din_end", 32'(ram_din), 32'h3C);
            default: ;
         endcase
         step();
      end

      // C64 side: request, handover, grants, skip, drop, reset mid-window.
      cur_t   = -2;
      dma_req = 1'b1;
      #1;
      chk("halt_before", 32'(cpu_halt), 32'd0);
      step();
      for (int t = 0; t <= 232; t++) begin
         cur_t      = t;
         slot_start = ((t % 16) == 0) || (t == 56);
         vic_ba     = (t != 80);
         dma_req    = (t < 100) || ((t >= 114) && (t < 120)) || (t >= 163);
         bus_din    = ((t >= 97) && (t <= 112)) ? 8'hA5 : (8'(t) ^ 8'h5A);
         reset      = (t >= 230);
         #1;
         e_dma  = ((t >= 49) && (t <= 80)) || ((t >= 97) && (t <= 112)) ||
                  ((t >= 225) && (t <= 230));
         e_halt = (t <= 113) || ((t >= 115) && (t <= 162)) || ((t >= 164) && (t <= 230));
         chk("dma_cycle", 32'(dma_cycle), 32'(e_dma));
         chk("cpu_halt",  32'(cpu_halt),  32'(e_halt));
         chk("bus_addr",  32'(bus_addr),  e_dma ? 32'hD020 : 32'h1234);
         chk("bus_dout",  32'(bus_dout),  e_dma ? 32'h05 : 32'h77);
         chk("bus_we",    32'(bus_we),    e_dma ? 32'd1 : 32'(!e_halt));
         case (t)
            49:  chk("dma_din_w0",    32'(dma_din), 32'hFF);
            50:  chk("dma_din_w1",    32'(dma_din), 32'h6B);
            64:  chk("dma_din_w15",   32'(dma_din), 32'h65);
            90:  chk("dma_din_hold",  32'(dma_din), 32'h0A);
            97:  chk("dma_din_noupd", 32'(dma_din), 32'h0A);
            112: chk("dma_din_rd",    32'(dma_din), 32'hA5);
            150: chk("dma_din_rdhld", 32'(dma_din), 32'hA5);
            200: chk("ram_din_hold",  32'(ram_din), 32'h3C);
            226: chk("dma_din_w3",    32'(dma_din), 32'hBB);
            231: begin
               chk("mrst_ram_cycle",  32'(ram_cycle),  32'd0);
               chk("mrst_sdram_ce",   32'(sdram_ce),   32'd0);
               chk("mrst_sdram_we",   32'(sdram_we),   32'd0);
               chk("mrst_sdram_addr", 32'(sdram_addr), 32'd0);
               chk("mrst_sdram_din",  32'(sdram_din),  32'd0);
               chk("mrst_ram_din",    32'(ram_din),    32'hFF);
               chk("mrst_dma_din",    32'(dma_din),    32'hFF);
            end
            default: ;
         endcase
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
